// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared types and constants for the decode-side scoreboard / bypass network.
//   MAX_AW / MAX_RW / MAX_SW : storage widths of scoreboard fields (cover up to
//                              256 registers and 16 tracked stages)
//   AW / SW                  : address / bypass-select widths of the default
//                              32-register, 3-stage configuration
//   sb_entry_t               : one scoreboard entry {valid, dst, rdy_stage}
//   byp_sel_t / BYP_RF       : bypass select encoding, 0 = register file
// -----------------------------------------------------------------------------
package proc_pkg;

  localparam int MAX_AW = 8;
  localparam int MAX_RW = 4;
  localparam int MAX_SW = 5;

  localparam int AW = 5;
  localparam int SW = 2;

  typedef logic [MAX_SW-1:0] byp_sel_t;

  // Select value meaning "operand comes from the register file".
  localparam byp_sel_t BYP_RF = '0;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] dst;
    logic [MAX_RW-1:0] rdy_stage;
  } sb_entry_t;

endpackage

// File: rtl/proc_regfile_nr1w.sv
// -----------------------------------------------------------------------------
// proc_regfile_nr1w
// Architectural register file with p_nsrc combinational read ports and one
// write port. x0 always reads 0 and is never written. A read of the register
// being written at the same edge returns the incoming value (write-through),
// so decode never sees a stale value during the retire cycle.
// Ports:
//   clk, reset         clock, asynchronous active-high reset (clears all regs)
//   rd_addr / rd_data  packed read addresses / read data, one slot per port
//   we, waddr, wdata   write port
// -----------------------------------------------------------------------------
module proc_regfile_nr1w #(
  parameter int p_nregs      = 32,
  parameter int p_nsrc       = 2,
  parameter int p_data_nbits = 32,
  localparam int aw = $clog2(p_nregs),
  localparam int dw = p_data_nbits
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_nsrc*aw-1:0]   rd_addr,
  output logic [p_nsrc*dw-1:0]   rd_data,
  input  logic                   we,
  input  logic [aw-1:0]          waddr,
  input  logic [dw-1:0]          wdata
);

  logic [dw-1:0] rf_reg [p_nregs];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < p_nregs; r++) begin
        rf_reg[r] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      rf_reg[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < p_nsrc; gi++) begin : g_rd
    logic [aw-1:0] raddr;
    logic [dw-1:0] rdata;

    assign raddr = rd_addr[gi*aw +: aw];

    always_comb begin
      rdata = rf_reg[raddr];
      if (raddr == '0) begin
        rdata = '0;
      end else if (we && (waddr == raddr)) begin
        rdata = wdata;
      end
    end

    assign rd_data[gi*dw +: dw] = rdata;
  end

endmodule

// File: rtl/proc_bypass_scoreboard_rf.sv
// -----------------------------------------------------------------------------
// proc_bypass_scoreboard_rf
// Register file, pending-write scoreboard and bypass network beside decode.
// Entry k describes the instruction currently in post-decode stage k
// (0 = X, 1 = M, ..., p_depth-1 writes the register file). For each decode
// source the youngest matching in-flight writer is found; if its result is
// already present in that stage the value is bypassed, otherwise decode stalls.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   d_src_en / d_src_addr  decode source enables / addresses (packed per port)
//   d_dst_en / d_dst_addr  decode destination
//   d_rdy_stage            first stage whose stage_data carries the result
//   d_fire                 decode instruction enters X at this edge
//   advance                pipeline shifts at this edge (0 = all stages hold)
//   squash                 kill the entry in stage k at this edge
//   stage_data             result value present in each stage (packed)
//   stall_d                decode must not fire
//   src_data / byp_sel     bypassed operands / source select (0 = RF, k+1 = stage k)
//   stall_cycles           saturating count of cycles with stall_d = 1
// -----------------------------------------------------------------------------
module proc_bypass_scoreboard_rf
  import proc_pkg::*;
#(
  parameter int p_nregs      = 1 << AW,
  parameter int p_nsrc       = 2,
  parameter int p_depth      = (1 << SW) - 1,
  parameter int p_data_nbits = 32,
  localparam int aw = $clog2(p_nregs),
  localparam int rw = (p_depth > 1) ? $clog2(p_depth) : 1,
  localparam int sw = $clog2(p_depth + 1),
  localparam int dw = p_data_nbits
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [p_nsrc-1:0]         d_src_en,
  input  logic [p_nsrc*aw-1:0]      d_src_addr,
  input  logic                      d_dst_en,
  input  logic [aw-1:0]             d_dst_addr,
  input  logic [rw-1:0]             d_rdy_stage,
  input  logic                      d_fire,
  input  logic                      advance,
  input  logic [p_depth-1:0]        squash,
  input  logic [p_depth*dw-1:0]     stage_data,
  output logic                      stall_d,
  output logic [p_nsrc*dw-1:0]      src_data,
  output logic [p_nsrc*sw-1:0]      byp_sel,
  output logic [31:0]               stall_cycles
);

  localparam int last = p_depth - 1;

  sb_entry_t     sb_reg  [p_depth];
  sb_entry_t     sb_next [p_depth];
  logic [dw-1:0] stage_val [p_depth];
  logic [p_nsrc-1:0] stall_vec;
  logic              accept;

  logic [p_nsrc*dw-1:0] rf_rd_data;
  logic                 rf_we;
  logic [aw-1:0]        rf_waddr;
  logic [dw-1:0]        rf_wdata;

  for (genvar gi = 0; gi < p_depth; gi++) begin : g_stage
    assign stage_val[gi] = stage_data[gi*dw +: dw];
  end

  // ---------------------------------------------------------------------------
  // Register file; the oldest tracked stage retires into it.
  // ---------------------------------------------------------------------------
  assign rf_we    = advance && sb_reg[last].valid && !squash[last];
  assign rf_waddr = sb_reg[last].dst[aw-1:0];
  assign rf_wdata = stage_val[last];

  proc_regfile_nr1w #(
    .p_nregs      (p_nregs),
    .p_nsrc       (p_nsrc),
    .p_data_nbits (p_data_nbits)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (d_src_addr),
    .rd_data (rf_rd_data),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // ---------------------------------------------------------------------------
  // Per-source dependency check and bypass mux.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < p_nsrc; gi++) begin : g_src
    logic [aw-1:0] addr;
    logic          active;
    logic          hit;
    logic          hit_ready;
    logic [sw-1:0] hit_sel;
    logic [dw-1:0] hit_data;
    logic          stall_src;
    logic [sw-1:0] sel;
    logic [dw-1:0] data;

    assign addr = d_src_addr[gi*aw +: aw];

    always_comb begin
      active    = d_src_en[gi] && (addr != '0);
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_sel   = sw'(BYP_RF);
      hit_data  = '0;
      // Scan oldest to youngest so the youngest match overwrites the rest.
      for (int k = p_depth - 1; k >= 0; k--) begin
        if (sb_reg[k].valid && (sb_reg[k].dst == MAX_AW'(addr))) begin
          hit       = 1'b1;
          hit_ready = (k >= int'(sb_reg[k].rdy_stage));
          hit_sel   = sw'(k + 1);
          hit_data  = stage_val[k];
        end
      end

      stall_src = 1'b0;
      sel       = sw'(BYP_RF);
      data      = '0;
      if (active) begin
        if (!hit) begin
          data = rf_rd_data[gi*dw +: dw];
        end else if (hit_ready) begin
          sel  = hit_sel;
          data = hit_data;
        end else begin
          stall_src = 1'b1;
        end
      end
    end

    assign stall_vec[gi]            = stall_src;
    assign byp_sel[gi*sw +: sw]     = sel;
    assign src_data[gi*dw +: dw]    = data;
  end

  assign stall_d = |stall_vec;

  // ---------------------------------------------------------------------------
  // Scoreboard shift / hold / squash.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept = advance && d_fire && !stall_d;
    for (int k = 0; k < p_depth; k++) begin
      sb_next[k] = sb_reg[k];
    end

    if (advance) begin
      // A squash on an entry kills it as it moves; the new X entry is never
      // affected by squash[0], which refers to the instruction leaving X.
      sb_next[0] = '0;
      if (accept) begin
        sb_next[0].valid     = d_dst_en && (d_dst_addr != '0);
        sb_next[0].dst       = MAX_AW'(d_dst_addr);
        sb_next[0].rdy_stage = MAX_RW'(d_rdy_stage);
      end
      for (int k = 1; k < p_depth; k++) begin
        sb_next[k] = sb_reg[k-1];
        if (squash[k-1]) begin
          sb_next[k].valid = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < p_depth; k++) begin
        if (squash[k]) begin
          sb_next[k].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < p_depth; k++) begin
        sb_reg[k] <= '0;
      end
      stall_cycles <= '0;
    end else begin
      for (int k = 0; k < p_depth; k++) begin
        sb_reg[k] <= sb_next[k];
      end
      if (stall_d && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_proc_bypass_scoreboard_rf.sv
// -----------------------------------------------------------------------------
// tb_proc_bypass_scoreboard_rf
// Directed scenarios followed by random traffic. The reference model keeps the
// in-flight instructions as a queue of {dst, ready stage, current stage}
// records plus an architectural register array, and derives stall / select /
// operand values from those records each cycle.
// -----------------------------------------------------------------------------
module tb_proc_bypass_scoreboard_rf;

  localparam int NSRC  = 2;
  localparam int DEPTH = 3;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int RW    = 2;
  localparam int SW    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NSRC-1:0]       d_src_en;
  logic [NSRC*AW-1:0]    d_src_addr;
  logic                  d_dst_en;
  logic [AW-1:0]         d_dst_addr;
  logic [RW-1:0]         d_rdy_stage;
  logic                  d_fire;
  logic                  advance;
  logic [DEPTH-1:0]      squash;
  logic [DEPTH*DW-1:0]   stage_data;
  logic                  stall_d;
  logic [NSRC*DW-1:0]    src_data;
  logic [NSRC*SW-1:0]    byp_sel;
  logic [31:0]           stall_cycles;

  always #5 clk = ~clk;

  proc_bypass_scoreboard_rf #(
    .p_nregs      (32),
    .p_nsrc       (NSRC),
    .p_depth      (DEPTH),
    .p_data_nbits (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d_src_en     (d_src_en),
    .d_src_addr   (d_src_addr),
    .d_dst_en     (d_dst_en),
    .d_dst_addr   (d_dst_addr),
    .d_rdy_stage  (d_rdy_stage),
    .d_fire       (d_fire),
    .advance      (advance),
    .squash       (squash),
    .stage_data   (stage_data),
    .stall_d      (stall_d),
    .src_data     (src_data),
    .byp_sel      (byp_sel),
    .stall_cycles (stall_cycles)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] dst;
    int            rdy;
    int            stage;
  } inst_t;

  inst_t       pipe_q[$];
  logic [31:0] m_rf [32];
  logic [31:0] m_cnt;
  bit          exp_stall;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    m_cnt     = '0;
    exp_stall = 1'b0;
  endtask

  // Expected outcome for source j from the in-flight instruction records.
  task automatic model_src(input int j, output bit stl, output int sel, output logic [31:0] data);
    logic [AW-1:0] a;
    int best;
    int brdy;
    a    = d_src_addr[j*AW +: AW];
    best = -1;
    brdy = 0;
    stl  = 1'b0;
    sel  = 0;
    data = '0;
    if (d_src_en[j] && a != '0) begin
      foreach (pipe_q[i]) begin
        if (pipe_q[i].dst == a && (best < 0 || pipe_q[i].stage < best)) begin
          best = pipe_q[i].stage;
          brdy = pipe_q[i].rdy;
        end
      end
      if (best < 0) begin
        data = m_rf[a];
      end else if (best >= brdy) begin
        sel  = best + 1;
        data = stage_data[best*DW +: DW];
      end else begin
        stl = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    bit          any;
    bit          s;
    int          sel;
    logic [31:0] d;
    any = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      model_src(j, s, sel, d);
      if (s) begin
        any = 1'b1;
      end else begin
        chk($sformatf("%s_sel%0d", tag, j), 64'(byp_sel[j*SW +: SW]), 64'(sel));
        chk($sformatf("%s_data%0d", tag, j), 64'(src_data[j*DW +: DW]), 64'(d));
      end
    end
    chk($sformatf("%s_stall", tag), 64'(stall_d), 64'(any));
    chk($sformatf("%s_count", tag), 64'(stall_cycles), 64'(m_cnt));
    exp_stall = any;
  endtask

  // Advance the model across one clock edge using the inputs just applied.
  task automatic model_edge();
    inst_t nq[$];
    inst_t it;
    if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    foreach (pipe_q[i]) begin
      it = pipe_q[i];
      if (squash[it.stage]) continue;
      if (advance) begin
        if (it.stage == DEPTH - 1) begin
          m_rf[it.dst] = stage_data[(DEPTH-1)*DW +: DW];
          continue;
        end
        it.stage++;
      end
      nq.push_back(it);
    end
    if (advance && d_fire && !exp_stall && d_dst_en && d_dst_addr != '0) begin
      it.dst   = d_dst_addr;
      it.rdy   = int'(d_rdy_stage);
      it.stage = 0;
      nq.push_back(it);
    end
    pipe_q = nq;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_d(input logic e0, input int a0, input logic e1, input int a1,
                       input logic de, input int dst, input int rdy, input logic fire);
    d_src_en    = {e1, e0};
    d_src_addr  = {AW'(a1), AW'(a0)};
    d_dst_en    = de;
    d_dst_addr  = AW'(dst);
    d_rdy_stage = RW'(rdy);
    d_fire      = fire;
    advance     = 1'b1;
    squash      = '0;
  endtask

  task automatic drive_eval(input string tag);
    stage_data = {$urandom, $urandom, $urandom};
    #1;
    check_outputs(tag);
  endtask

  task automatic commit();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    drive_eval(tag);
    commit();
  endtask

  logic [31:0] cnt_before;
  logic [31:0] old7;

  initial begin
    reset = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    stage_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall_d), 64'(0));
    chk("rst_sel",   64'(byp_sel), 64'(0));
    chk("rst_count", 64'(stall_cycles), 64'(0));
    reset = 1'b0;

    // ALU result x5 ready in X: bypass from X, then M, then W, then the RF.
    set_d(0, 0, 0, 0, 1, 5, 0, 1); step("t2_fire");
    set_d(1, 5, 0, 0, 0, 0, 0, 1);
    drive_eval("t2_x");
    chk("t2_selx", 64'(byp_sel[SW-1:0]), 64'(1));
    chk("t2_datax", 64'(src_data[DW-1:0]), 64'(stage_data[DW-1:0]));
    commit();
    drive_eval("t2_m");
    chk("t2_selm", 64'(byp_sel[SW-1:0]), 64'(2));
    commit();
    drive_eval("t2_w");
    chk("t2_selw", 64'(byp_sel[SW-1:0]), 64'(3));
    commit();
    step("t2_rf");

    // Load x7 ready in M: one stall cycle, then bypass from M.
    set_d(0, 0, 0, 0, 1, 7, 1, 1); step("t3_fire");
    cnt_before = m_cnt;
    set_d(1, 7, 0, 0, 0, 0, 0, 1);
    drive_eval("t3_stall");
    chk("t3_stall1", 64'(stall_d), 64'(1));
    commit();
    drive_eval("t3_byp");
    chk("t3_sel", 64'(byp_sel[SW-1:0]), 64'(2));
    chk("t3_cnt", 64'(stall_cycles), 64'(cnt_before + 1));
    commit();
    repeat (3) step("t3_drain");

    // Two writers of x9 in X and M: youngest (X) wins; x0 reads as zero.
    set_d(0, 0, 0, 0, 1, 9, 0, 1); step("t4_a");
    step("t4_b");
    set_d(1, 9, 1, 0, 0, 0, 0, 0);
    drive_eval("t4_rd");
    chk("t4_sel9", 64'(byp_sel[SW-1:0]), 64'(1));
    chk("t4_sel0", 64'(byp_sel[2*SW-1:SW]), 64'(0));
    chk("t4_dat0", 64'(src_data[2*DW-1:DW]), 64'(0));
    commit();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step("t4_drain");

    // Squashed load of x7 never reaches the RF.
    old7 = m_rf[7];
    set_d(0, 0, 0, 0, 1, 7, 1, 1); step("t5_fire");
    set_d(1, 7, 0, 0, 0, 0, 0, 1);
    squash = 3'b001;
    step("t5_squash");
    squash = '0;
    for (int i = 0; i < 3; i++) begin
      drive_eval("t5_rd");
      chk("t5_nostall", 64'(stall_d), 64'(0));
      chk("t5_x7", 64'(src_data[DW-1:0]), 64'(old7));
      commit();
    end

    // Pipeline frozen for 4 cycles behind a pending load.
    set_d(0, 0, 0, 0, 1, 7, 1, 1); step("t6_fire");
    cnt_before = m_cnt;
    set_d(1, 7, 0, 0, 0, 0, 0, 1);
    advance = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_eval("t6_hold");
      chk("t6_stall", 64'(stall_d), 64'(1));
      commit();
    end
    advance = 1'b1;
    drive_eval("t6_resume");
    chk("t6_cnt", 64'(stall_cycles), 64'(cnt_before + 4));
    commit();
    step("t6_byp");

    // Reset mid-run with three valid entries.
    set_d(0, 0, 0, 0, 1, 1, 2, 1); step("t1_a");
    set_d(0, 0, 0, 0, 1, 2, 2, 1); step("t1_b");
    set_d(0, 0, 0, 0, 1, 3, 2, 1); step("t1_c");
    set_d(1, 3, 1, 2, 0, 0, 0, 1);
    drive_eval("t1_pre");
    reset = 1'b1;
    #1;
    model_reset();
    chk("t1_stall", 64'(stall_d), 64'(0));
    chk("t1_sel",   64'(byp_sel), 64'(0));
    chk("t1_data",  64'(src_data), 64'(0));
    chk("t1_count", 64'(stall_cycles), 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step("t1_after");

    // Random traffic over a small register window to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      d_src_en    = 2'($urandom);
      d_src_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      d_dst_en    = ($urandom_range(0, 3) != 0);
      d_dst_addr  = 5'($urandom_range(0, 7));
      d_rdy_stage = 2'($urandom_range(0, 2));
      d_fire      = 1'($urandom_range(0, 1));
      advance     = ($urandom_range(0, 4) != 0);
      squash      = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
